muldiv_sequencer: RTL and testbench

Multi-cycle controller for MIPS MULT/MULTU/DIV/DIVU. It time-shares the existing 32-bit ALU adder: the block drives the adder's operand and ALUOp inputs and consumes its result to perform 32 iterations of shift-add multiply or restoring divide. It holds the 64-bit result in HI/LO for MFHI/MFLO and sits beside the execute stage, which stalls on `busy`.

---
 rtl/muldiv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the shared ALU adder.
// Shift-add multiply and restoring divide on magnitudes, then a two-step sign fix-up.
module muldiv_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] alu_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE
    } state_t;

    state_t      state;
    logic        is_div;
    logic        sa;
    logic        sb;
    logic        z;
    logic [31:0] rs_r;
    logic [31:0] rt_r;
    logic [31:0] amag;
    logic [31:0] mreg;
    logic [4:0]  cnt;

    logic [31:0] div_a;
    logic [31:0] bmag;
    logic        carry;
    logic        div_ge;
    logic        neg_lo;
    logic        neg_hi;

    assign div_a  = {hi[30:0], lo[31]};
    assign bmag   = sb ? alu_result : rt_r;
    assign carry  = (alu_result < hi);
    // hi[31] set means the shifted partial remainder is really 33 bits and always fits
    assign div_ge = hi[31] | (div_a >= mreg);
    assign neg_lo = sa ^ sb;
    assign neg_hi = is_div ? sa : (sa ^ sb);

    always_comb begin
        alu_a  = 32'h0;
        alu_b  = 32'h0;
        alu_op = ALU_NOP;
        case (state)
            NEG_A: begin
                alu_op = ALU_SUB;
                alu_b  = rs_r;
            end
            NEG_B: begin
                alu_op = ALU_SUB;
                alu_b  = rt_r;
            end
            ITER: begin
                if (is_div) begin
                    alu_op = ALU_SUB;
                    alu_a  = div_a;
                end else begin
                    alu_op = ALU_ADD;
                    alu_a  = hi;
                end
                alu_b = mreg;
            end
            FIX_LO: begin
                alu_op = ALU_SUB;
                alu_b  = lo;
            end
            FIX_HI: begin
                if (is_div) begin
                    alu_op = ALU_SUB;
                    alu_b  = hi;
                end else begin
                    alu_op = ALU_ADD;
                    alu_a  = ~hi;
                    alu_b  = {31'b0, z};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= 32'h0;
            lo    <= 32'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        is_div <= op[1];
                        sa     <= ~op[0] & rs[31];
                        sb     <= ~op[0] & rt[31];
                        rs_r   <= rs;
                        rt_r   <= rt;
                        busy   <= 1'b1;
                        state  <= NEG_A;
                    end
                end
                NEG_A: begin
                    amag  <= sa ? alu_result : rs_r;
                    state <= NEG_B;
                end
                NEG_B: begin
                    if (is_div && (bmag == 32'h0)) begin
                        hi    <= rs_r;
                        lo    <= 32'hFFFF_FFFF;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt   <= 5'd31;
                        hi    <= 32'h0;
                        lo    <= is_div ? amag : bmag;
                        mreg  <= is_div ? bmag : amag;
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (is_div) begin
                        if (div_ge) begin
                            hi <= alu_result;
                            lo <= {lo[30:0], 1'b1};
                        end else begin
                            hi <= div_a;
                            lo <= {lo[30:0], 1'b0};
                        end
                    end else if (lo[0]) begin
                        hi <= {carry, alu_result[31:1]};
                        lo <= {alu_result[0], lo[31:1]};
                    end else begin
                        hi <= {1'b0, hi[31:1]};
                        lo <= {hi[0], lo[31:1]};
                    end
                    if (cnt == 5'd0) begin
                        state <= FIX_LO;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                FIX_LO: begin
                    if (neg_lo) begin
                        lo <= alu_result;
                    end
                    // z tells the high-word negation whether the low word's +1 carried out
                    z     <= (lo == 32'h0);
                    state <= FIX_HI;
                end
                FIX_HI: begin
                    if (neg_hi) begin
                        hi <= alu_result;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with a behavioural ALU adder and
// an arithmetic reference model for products, quotients and remainders.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] alu_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    muldiv_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .alu_result (alu_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared execute-stage adder
    always_comb begin
        case (alu_op)
            4'b0001: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] sp;
        logic signed [31:0] sa32;
        logic signed [31:0] sb32;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [63:0] up;
        case (o)
            2'b00: begin
                sa64 = {{32{a[31]}}, a};
                sb64 = {{32{b[31]}}, b};
                sp = sa64 * sb64;
                return sp;
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                return up;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa32 = a;
                sb32 = b;
                sq = sa32 / sb32;
                sr = sa32 % sb32;
                return {sr, sq};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op and wait for done; lat is the cycle index where done is seen (-1 on timeout)
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        start = 1'b1;
        op = o;
        rs = a;
        rt = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        rs = 32'h0;
        rt = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: busy=%b done=%b, want 0 0", busy, done);
        end
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_err++;
            $display("FAIL reset_hilo: hi=%h lo=%h, want 0 0", hi, lo);
        end
        n_cmp++;
        if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0) begin
            n_err++;
            $display("FAIL reset_alu: a=%h b=%h op=%h, want 0 0 0", alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  vo [10];
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] eh [10];
        logic [31:0] el [10];
        int lat;
        vo[0] = 2'b01; va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; eh[0] = 32'hFFFF_FFFE; el[0] = 32'h0000_0001;
        vo[1] = 2'b00; va[1] = 32'hFFFF_FFFD; vb[1] = 32'd5;         eh[1] = 32'hFFFF_FFFF; el[1] = 32'hFFFF_FFF1;
        vo[2] = 2'b00; va[2] = 32'hFFFF_FFFC; vb[2] = 32'hFFFF_FFFC; eh[2] = 32'h0;         el[2] = 32'h10;
        vo[3] = 2'b10; va[3] = 32'hFFFF_FFF9; vb[3] = 32'd2;         eh[3] = 32'hFFFF_FFFF; el[3] = 32'hFFFF_FFFD;
        vo[4] = 2'b11; va[4] = 32'd100;       vb[4] = 32'd7;         eh[4] = 32'h2;         el[4] = 32'hE;
        vo[5] = 2'b10; va[5] = 32'h8000_0000; vb[5] = 32'hFFFF_FFFF; eh[5] = 32'h0;         el[5] = 32'h8000_0000;
        vo[6] = 2'b10; va[6] = 32'd7;         vb[6] = 32'hFFFF_FFFE; eh[6] = 32'h1;         el[6] = 32'hFFFF_FFFD;
        vo[7] = 2'b00; va[7] = 32'h8000_0000; vb[7] = 32'h8000_0000; eh[7] = 32'h4000_0000; el[7] = 32'h0;
        vo[8] = 2'b00; va[8] = 32'h8000_0000; vb[8] = 32'd2;         eh[8] = 32'hFFFF_FFFF; el[8] = 32'h0;
        vo[9] = 2'b11; va[9] = 32'hFFFF_FFFF; vb[9] = 32'h8000_0000; eh[9] = 32'h7FFF_FFFF; el[9] = 32'h1;
        for (int i = 0; i < 10; i++) begin
            issue(vo[i], va[i], vb[i], lat);
            n_cmp++;
            if (lat !== 37) begin
                n_err++;
                $display("FAIL dir%0d_latency: done at cycle %0d, want 37", i, lat);
            end
            n_cmp++;
            if (hi !== eh[i] || lo !== el[i]) begin
                n_err++;
                $display("FAIL dir%0d_result: hi=%h lo=%h, want hi=%h lo=%h", i, hi, lo, eh[i], el[i]);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_pulse: done=%b busy=%b after DONE, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        issue(2'b11, 32'd5, 32'd0, lat);
        n_cmp++;
        if (lat !== 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL divz_latency: done at cycle %0d busy=%b, want 3 0", lat, busy);
        end
        n_cmp++;
        if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL divz_result: hi=%h lo=%h, want 5 ffffffff", hi, lo);
        end
        issue(2'b10, 32'hFFFF_FFF0, 32'd0, lat);
        n_cmp++;
        if (lat !== 3 || hi !== 32'hFFFF_FFF0 || lo !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL divz_signed: lat=%0d hi=%h lo=%h, want 3 fffffff0 ffffffff", lat, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        rs = 32'd6;
        rt = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_busy: busy=%b in cycle 1, want 1", busy);
        end
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                start = 1'b1;
                op = 2'b11;
                rs = 32'd100;
                rt = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        n_cmp++;
        if (lat !== 37 || hi !== 32'h0 || lo !== 32'd42) begin
            n_err++;
            $display("FAIL ignore_start: lat=%0d hi=%h lo=%h, want 37 0 2a", lat, hi, lo);
        end
        issue(2'b11, 32'd1000, 32'd33, lat);
        n_cmp++;
        if (lat !== 37 || hi !== 32'd10 || lo !== 32'd30) begin
            n_err++;
            $display("FAIL back_to_back: lat=%0d hi=%h lo=%h, want 37 a 1e", lat, hi, lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen_done;
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        rs = 32'hFFFF_FFFF;
        rt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_err++;
            $display("FAIL reset_discard: %0d cycles busy/done after reset, want 0", seen_done);
        end
        issue(2'b00, 32'hFFFF_FFF9, 32'd9, lat);
        n_cmp++;
        if (lat !== 37 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFC1) begin
            n_err++;
            $display("FAIL after_reset: lat=%0d hi=%h lo=%h, want 37 ffffffff ffffffc1", lat, hi, lo);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 255);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int lat;
        int want_lat;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            exp = ref_model(o, a, b);
            want_lat = (o[1] && b == 32'h0) ? 3 : 37;
            issue(o, a, b, lat);
            n_cmp++;
            if (lat !== want_lat || hi !== exp[63:32] || lo !== exp[31:0]) begin
                n_err++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h, want lat=%0d hi=%h lo=%h",
                         i, o, a, b, lat, hi, lo, want_lat, exp[63:32], exp[31:0]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
